iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu.sv | 182 ++++++++++++++++++
 tb/tb_iter_alu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arithmetic ops plus WIDTH-cycle
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module iter_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alucontrol,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;

    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [5:0]       r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_opnd, r_hi, r_lo;
    logic [WIDTH-1:0] r_result, r_result_hi;
    logic             r_zero, r_overflow, r_div_by_zero, r_done;

    logic             w_accept, w_iter_op, w_last;
    logic [WIDTH-1:0] w_sum, w_diff, w_res;
    logic             w_ovf;
    logic [WIDTH:0]   w_mul_sum, w_rem_sh;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;

    // Signed overflow of x + y = r: operands agree in sign, result does not.
    function automatic logic f_add_ovf(input logic sx, input logic sy, input logic sr);
        return (sx == sy) && (sr != sx);
    endfunction

    assign w_iter_op = (alucontrol == OP_MULU) || (alucontrol == OP_DIVU);
    assign w_last    = (r_cnt == CNT_LAST);
    assign w_sum     = a + b;
    assign w_diff    = a - b;

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (alucontrol)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = f_add_ovf(a[WIDTH-1], b[WIDTH-1], w_sum[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = f_add_ovf(a[WIDTH-1], ~b[WIDTH-1], w_diff[WIDTH-1]);
            end
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_XOR:  w_res = a ^ b;
            OP_NOR:  w_res = ~(a | b);
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: w_res = '0;
        endcase
    end

    // One iteration step. Multiply: {hi,lo} holds partial product over the
    // shrinking multiplier. Divide: hi is the remainder, lo shifts dividend
    // out and quotient bits in; b=0 naturally yields all-ones and rem=a.
    assign w_mul_sum  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : '0)};
    assign w_rem_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_opnd});
    assign w_div_diff = w_rem_sh[WIDTH-1:0] - r_opnd;

    always_comb begin
        w_hi_nxt = w_mul_sum[WIDTH:1];
        w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            w_hi_nxt = w_div_ge ? w_div_diff : w_rem_sh[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ge};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_iter_op) w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= (alucontrol == OP_DIVU);
        end else if (r_state == RUN) begin
            r_cnt    <= r_cnt + 6'd1;
        end
    end

    // Working registers are invisible outside RUN, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_iter_op) begin
            r_opnd <= (alucontrol == OP_DIVU) ? b : a;
            r_lo   <= (alucontrol == OP_DIVU) ? a : b;
            r_hi   <= '0;
        end else if (r_state == RUN) begin
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result      <= '0;
            r_result_hi   <= '0;
            r_zero        <= 1'b0;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && !w_iter_op) begin
                r_result      <= w_res;
                r_result_hi   <= '0;
                r_zero        <= (w_res == '0);
                r_overflow    <= w_ovf;
                r_div_by_zero <= 1'b0;
                r_done        <= 1'b1;
            end else if (r_state == RUN && w_last) begin
                r_result      <= w_lo_nxt;
                r_result_hi   <= w_hi_nxt;
                r_zero        <= (w_lo_nxt == '0);
                r_overflow    <= 1'b0;
                r_div_by_zero <= r_is_div && (r_opnd == '0);
                r_done        <= 1'b1;
            end
        end
    end

    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign zero        = r_zero;
    assign overflow    = r_overflow;
    assign div_by_zero = r_div_by_zero;
    assign done        = r_done;
    assign busy        = (r_state == RUN);

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu at WIDTH=8.
module tb_iter_alu;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, SLT = 4'd4;
    localparam logic [3:0] XOR_ = 4'd5, NOR_ = 4'd6, SLTU = 4'd7, MULU = 4'd8, DIVU = 4'd9;

    logic       clk, reset, start;
    logic [7:0] a, b;
    logic [3:0] alucontrol;
    logic [7:0] result, result_hi;
    logic       zero, overflow, div_by_zero, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    iter_alu #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .alucontrol(alucontrol), .result(result), .result_hi(result_hi),
        .zero(zero), .overflow(overflow), .div_by_zero(div_by_zero),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operation for exactly one rising edge; returns #1 after it.
    task automatic issue(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        alucontrol = op; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; alucontrol = ADD;
        #2;
        n_cmp++;
        if ({result, result_hi} !== 16'h0000) begin
            n_err++; $display("FAIL reset_data: got %h_%h want 00_00", result_hi, result);
        end
        n_cmp++;
        if ({zero, overflow, div_by_zero, busy, done} !== 5'b00000) begin
            n_err++; $display("FAIL reset_flags: got %b want 00000",
                              {zero, overflow, div_by_zero, busy, done});
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_add;
        issue(ADD, 8'd94, 8'd12);
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_err++; $display("FAIL add_handshake: got done/busy %b want 10", {done, busy});
        end
        n_cmp++;
        if ({result_hi, result} !== {8'h00, 8'd106}) begin
            n_err++; $display("FAIL add_result: got %h_%h want 00_6a", result_hi, result);
        end
        n_cmp++;
        if ({zero, overflow, div_by_zero} !== 3'b000) begin
            n_err++; $display("FAIL add_flags: got %b want 000", {zero, overflow, div_by_zero});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy, result} !== {2'b00, 8'd106}) begin
            n_err++; $display("FAIL add_done_once: got done/busy %b result %h want 00 6a",
                              {done, busy}, result);
        end
    endtask

    task automatic test_single_ops;
        logic [3:0] t_op[13];
        logic [7:0] t_a[13], t_b[13], t_r[13];
        logic [1:0] t_zo[13];
        t_op = '{SUB, ADD, SUB, SUB, AND_, OR_, XOR_, NOR_, SLT, SLTU, SLT, 4'd12, ADD};
        t_a  = '{8'd12, 8'd100, 8'd55, 8'h80, 8'hF0, 8'hF0, 8'hFF, 8'h0F, 8'h80, 8'h80, 8'h05, 8'h12, 8'hFF};
        t_b  = '{8'd94, 8'd100, 8'd55, 8'h01, 8'h3C, 8'h0C, 8'h0F, 8'hF0, 8'h01, 8'h01, 8'hFB, 8'h34, 8'h01};
        t_r  = '{8'hAE, 8'hC8, 8'h00, 8'h7F, 8'h30, 8'hFC, 8'hF0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        t_zo = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
        for (int i = 0; i < 13; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            n_cmp++;
            if ({done, busy, result_hi, result} !== {2'b10, 8'h00, t_r[i]}) begin
                n_err++; $display("FAIL single_op%0d_result: got done/busy %b %h_%h want 10 00_%h",
                                  i, {done, busy}, result_hi, result, t_r[i]);
            end
            n_cmp++;
            if ({zero, overflow, div_by_zero} !== {t_zo[i], 1'b0}) begin
                n_err++; $display("FAIL single_op%0d_flags: got zod %b want %b0",
                                  i, {zero, overflow, div_by_zero}, t_zo[i]);
            end
        end
    endtask

    task automatic test_mulu;
        issue(MULU, 8'd94, 8'd12);
        n_cmp++;
        if ({done, busy} !== 2'b01) begin
            n_err++; $display("FAIL mulu_enter_run: got done/busy %b want 01", {done, busy});
        end
        for (int i = 1; i <= 8; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            @(posedge clk); #1;
            if (i < 8) begin
                n_cmp++;
                if ({done, busy, result} !== {2'b01, 8'h00}) begin
                    n_err++; $display("FAIL mulu_busy_%0d: got done/busy %b result %h want 01 00",
                                      i, {done, busy}, result);
                end
            end else begin
                n_cmp++;
                if ({done, busy, result_hi, result} !== {2'b10, 8'h04, 8'h68}) begin
                    n_err++; $display("FAIL mulu_result: got done/busy %b %h_%h want 10 04_68",
                                      {done, busy}, result_hi, result);
                end
                n_cmp++;
                if ({zero, overflow, div_by_zero} !== 3'b000) begin
                    n_err++; $display("FAIL mulu_flags: got %b want 000", {zero, overflow, div_by_zero});
                end
            end
            if (i == 2 || i == 5) begin
                start = 1'b1; alucontrol = (i == 2) ? ADD : DIVU;
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy, result_hi, result} !== {2'b00, 8'h04, 8'h68}) begin
            n_err++; $display("FAIL mulu_hold: got done/busy %b %h_%h want 00 04_68",
                              {done, busy}, result_hi, result);
        end
    endtask

    task automatic test_divu;
        int n;
        issue(DIVU, 8'd94, 8'd12);
        n = 1;
        while (done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (n !== 9) begin
            n_err++; $display("FAIL divu_latency: got %0d edges want 9 (incl accept)", n);
        end
        n_cmp++;
        if ({result_hi, result, div_by_zero, zero} !== {8'd10, 8'd7, 2'b00}) begin
            n_err++; $display("FAIL divu_result: got %h_%h dz %b z %b want 0a_07 0 0",
                              result_hi, result, div_by_zero, zero);
        end
        issue(DIVU, 8'd94, 8'd0);
        n = 1;
        while (done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (n !== 9) begin
            n_err++; $display("FAIL divz_latency: got %0d edges want 9 (incl accept)", n);
        end
        n_cmp++;
        if ({result_hi, result, div_by_zero, zero, busy} !== {8'd94, 8'hFF, 3'b100}) begin
            n_err++; $display("FAIL divz_result: got %h_%h dz %b z %b busy %b want 5e_ff 1 0 0",
                              result_hi, result, div_by_zero, zero, busy);
        end
    endtask

    task automatic test_reset_midrun;
        logic seen;
        issue(MULU, 8'd94, 8'd12);
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({result_hi, result} !== 16'h0000) begin
            n_err++; $display("FAIL midrun_reset_data: got %h_%h want 00_00", result_hi, result);
        end
        n_cmp++;
        if ({zero, overflow, div_by_zero, busy, done} !== 5'b00000) begin
            n_err++; $display("FAIL midrun_reset_flags: got %b want 00000",
                              {zero, overflow, div_by_zero, busy, done});
        end
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 || result !== 8'h00) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL midrun_no_done: got activity %b want 0", seen);
        end
        issue(ADD, 8'd3, 8'd4);
        n_cmp++;
        if ({done, result} !== {1'b1, 8'd7}) begin
            n_err++; $display("FAIL post_reset_add: got done %b result %h want 1 07", done, result);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        issue(DIVU, 8'd94, 8'd12);
        n = 1;
        while (done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        alucontrol = ADD; a = 8'd20; b = 8'd22; start = 1'b1;
        n_cmp++;
        if ({done, busy, result_hi, result} !== {2'b10, 8'd10, 8'd7}) begin
            n_err++; $display("FAIL b2b_div_done: got done/busy %b %h_%h want 10 0a_07",
                              {done, busy}, result_hi, result);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if ({done, busy, result_hi, result, zero} !== {2'b10, 8'h00, 8'd42, 1'b0}) begin
            n_err++; $display("FAIL b2b_add_done: got done/busy %b %h_%h z %b want 10 00_2a 0",
                              {done, busy}, result_hi, result, zero);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy, result} !== {2'b00, 8'd42}) begin
            n_err++; $display("FAIL b2b_settle: got done/busy %b result %h want 00 2a",
                              {done, busy}, result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_single_ops();
        test_mulu();
        test_divu();
        test_reset_midrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
